// File: rtl/icache_ctrl_pkg.sv
// Shared types and widths for the ICACHE_INS0 write-side controller.
// Holds the controller state encoding and the saturating counter helper.
package icache_ctrl_pkg;

  localparam int ICACHE_ADDR_WIDTH = 10;
  localparam int ICACHE_DATA_WIDTH = 32;
  localparam int WR_COUNT_WIDTH    = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WR_COUNT_WIDTH-1:0] sat_inc(input logic [WR_COUNT_WIDTH-1:0] v);
    logic [WR_COUNT_WIDTH-1:0] res;
    if (v == {WR_COUNT_WIDTH{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(WR_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/icache_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above ptr_i,
// wrapping modulo NUM_REQ. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  int          cand_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic        found_s;

  // Scan candidates starting at the pointer; the first valid one wins.
  always_comb begin
    grant_o    = '0;
    idx_o      = '0;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = int'(ptr_i) + off;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = IDX_W'(cand_s);
      if (!found_s && valid_i[cand_idx_s]) begin
        found_s             = 1'b1;
        grant_o[cand_idx_s] = 1'b1;
        idx_o               = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/icache_wr_arbiter.sv
// Write-port controller for the ICACHE_INS0 RAM: clears the array after reset or
// on command, otherwise shares the write port round-robin among NUM_REQ requesters.
module icache_wr_arbiter
  import icache_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = ICACHE_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = ICACHE_DATA_WIDTH,
  parameter int                    NUM_REQ      = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  parameter bit                    CLR_ON_RESET = 1'b1,
  localparam int                   IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          tb_wr_rst,
  input  logic                          clr_start,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic                          init_busy,
  output logic                          init_done,
  output logic [IDX_W-1:0]              grant_id,
  output logic [WR_COUNT_WIDTH-1:0]     wr_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  wr_state_e                 state_q;
  logic [ADDR_WIDTH-1:0]     sweep_q;
  logic [IDX_W-1:0]          ptr_q;
  logic                      start_pend_q;
  logic                      wr_en_q;
  logic [ADDR_WIDTH-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0]     wr_data_q;
  logic                      busy_q;
  logic                      done_q;
  logic [IDX_W-1:0]          grant_id_q;
  logic [WR_COUNT_WIDTH-1:0] wr_count_q;

  logic [NUM_REQ-1:0]        grant_s;
  logic [IDX_W-1:0]          gidx_s;
  logic [IDX_W-1:0]          ptr_d;
  logic                      accept_s;
  logic                      xfer_s;
  logic                      clear_go_s;
  logic [ADDR_WIDTH-1:0]     sel_addr_s;
  logic [DATA_WIDTH-1:0]     sel_data_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .idx_o   (gidx_s)
  );

  // Requests are only accepted in a quiet IDLE: not draining the sweep tail and
  // not waiting to start a deferred or post-reset clear.
  always_comb begin
    accept_s  = (state_q == IDLE) && !busy_q && !start_pend_q;
    req_ready = '0;
    if (tb_wr_rst) begin
      req_ready = '0;
    end else if (accept_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Transfer decode, selected payload and next round-robin pointer.
  always_comb begin
    xfer_s     = |(req_valid & req_ready);
    sel_addr_s = req_addr[gidx_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data_s = req_data[gidx_s*DATA_WIDTH +: DATA_WIDTH];
    clear_go_s = (state_q == IDLE) && !busy_q && (start_pend_q || (clr_start && !xfer_s));
    if (int'(gidx_s) == NUM_REQ - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = gidx_s + IDX_W'(1);
    end
  end

  // Controller FSM with the registered RAM write stage and status outputs.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q      <= IDLE;
      sweep_q      <= '0;
      ptr_q        <= '0;
      start_pend_q <= CLR_ON_RESET;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      grant_id_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      // busy tracks the sweep writes as they appear on the RAM pins.
      busy_q <= (state_q == CLEAR);
      if (busy_q && (state_q == IDLE)) begin
        done_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          sweep_q <= '0;
          if (xfer_s) begin
            wr_en_q      <= 1'b1;
            wr_addr_q    <= sel_addr_s;
            wr_data_q    <= sel_data_s;
            grant_id_q   <= gidx_s;
            ptr_q        <= ptr_d;
            wr_count_q   <= sat_inc(wr_count_q);
            // A clear requested alongside a transfer waits one cycle so the write lands first.
            start_pend_q <= clr_start;
          end else begin
            wr_en_q <= 1'b0;
            if (clear_go_s) begin
              state_q      <= CLEAR;
              start_pend_q <= 1'b0;
            end
          end
        end
        CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= sweep_q;
          wr_data_q <= INIT_VALUE;
          sweep_q   <= sweep_q + ADDR_ONE;
          if (sweep_q == LAST_ADDR) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign init_busy   = busy_q;
  assign init_done   = done_q;
  assign grant_id    = grant_id_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_icache_wr_arbiter.sv
// Scoreboard bench for icache_wr_arbiter: expected RAM writes are queued by the
// stimulus and checked by an independent monitor on the falling clock edge.
module tb_icache_wr_arbiter;

  logic        wr_clk;
  logic        tb_wr_rst;
  logic        clr_start;
  logic [1:0]  req_valid;
  logic [19:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        init_busy;
  logic        init_done;
  logic [0:0]  grant_id;
  logic [15:0] wr_count;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [0:0]  gid;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [1024];
  int          n_checks = 0;
  int          n_fail   = 0;

  icache_wr_arbiter dut (
    .wr_clk      (wr_clk),
    .tb_wr_rst   (tb_wr_rst),
    .clr_start   (clr_start),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .init_busy   (init_busy),
    .init_done   (init_done),
    .grant_id    (grant_id),
    .wr_count    (wr_count)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [9:0] a, input logic [31:0] d, input logic [0:0] g, input logic [15:0] c);
    exp_t e;
    e.addr = a; e.data = d; e.gid = g; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep(input int last, input logic [15:0] c);
    for (int i = 0; i <= last; i++) push(10'(i), 32'h0, 1'b0, c);
  endtask

  // Wait until every queued write has been observed, within a cycle budget.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge wr_clk); #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every presented write must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge wr_clk);
      if (init_busy) check("ready_in_clear", 64'(req_ready), 64'd0);
      if (ram_wr_en) begin
        mem[ram_wr_addr] = ram_wr_data;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {22'd0, ram_wr_addr, ram_wr_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write", {5'd0, grant_id, wr_count, ram_wr_addr, ram_wr_data},
                {5'd0, e.gid, e.cnt, e.addr, e.data});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rdy [4];
    int n;
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;

    // Reset state, with both requesters asking
    tb_wr_rst = 1'b1; clr_start = 1'b0;
    req_valid = 2'b11;
    req_addr  = {10'd9, 10'd5};
    req_data  = {32'h5A5A5A5A, 32'hA5A5A5A5};
    #12;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_outputs", {31'd0, ram_wr_en, ram_wr_addr, init_busy, init_done, grant_id, wr_count},
          64'd0);

    // 1: automatic sweep after reset
    push_sweep(1023, 16'd0);
    @(negedge wr_clk); tb_wr_rst = 1'b0;
    drain(1100);
    req_valid = 2'b00;
    @(negedge wr_clk); #1;
    check("init_done_after_sweep", {62'd0, init_done, init_busy}, {62'd0, 1'b1, 1'b0});

    // 2: both requesters, alternating grants
    push(10'd5, 32'hA5A5A5A5, 1'b0, 16'd1);
    push(10'd9, 32'h5A5A5A5A, 1'b1, 16'd2);
    push(10'd5, 32'hA5A5A5A5, 1'b0, 16'd3);
    push(10'd9, 32'h5A5A5A5A, 1'b1, 16'd4);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1; check("rr_ready", 64'(req_ready), 64'(exp_rdy[k]));
      @(negedge wr_clk); #1;
    end
    req_valid = 2'b00;
    drain(10);

    // 3: single requester 1 at the top address
    req_addr[19:10] = 10'h3FF; req_data[63:32] = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) push(10'h3FF, 32'hFFFFFFFF, 1'b1, 16'(5 + k));
    req_valid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1; check("single_ready", 64'(req_ready), 64'(2'b10));
      @(negedge wr_clk); #1;
    end
    req_valid = 2'b00;
    drain(10);
    check("grant_id_single", 64'(grant_id), 64'd1);

    // 4: clear requested on the same edge as a transfer
    req_addr[9:0] = 10'd7; req_data[31:0] = 32'h12345678;
    push(10'd7, 32'h12345678, 1'b0, 16'd9);
    push_sweep(1023, 16'd9);
    req_valid = 2'b01; clr_start = 1'b1;
    @(negedge wr_clk); #1;
    req_valid = 2'b00; clr_start = 1'b0;
    drain(1100);
    @(negedge wr_clk); #1;
    check("readback_addr7", 64'(mem[7]), 64'd0);
    check("busy_after_clear", 64'(init_busy), 64'd0);

    // 5: reset in the middle of a sweep
    push_sweep(300, 16'd9);
    clr_start = 1'b1;
    @(negedge wr_clk); #1;
    clr_start = 1'b0;
    n = 0;
    while (!(ram_wr_en && ram_wr_addr == 10'd300) && n < 400) begin
      @(negedge wr_clk); #1;
      n++;
    end
    check("reach_addr300", 64'(n < 400), 64'd1);
    tb_wr_rst = 1'b1; req_valid = 2'b11;
    #1;
    check("midsweep_queue", 64'(exp_q.size()), 64'd0);
    check("midsweep_ready", 64'(req_ready), 64'd0);
    check("midsweep_outputs", {31'd0, ram_wr_en, ram_wr_addr, init_busy, init_done, grant_id, wr_count},
          64'd0);
    req_valid = 2'b00;
    push_sweep(1023, 16'd0);
    @(negedge wr_clk); tb_wr_rst = 1'b0;
    drain(1100);
    @(negedge wr_clk); #1;
    check("done_after_resweep", 64'(init_done), 64'd1);

    // 6: write counter saturation
    force dut.wr_count_q = 16'hFFFE;
    #1;
    release dut.wr_count_q;
    #1;
    check("count_preload", 64'(wr_count), 64'hFFFE);
    req_addr[9:0] = 10'd11; req_data[31:0] = 32'hC0DE0001;
    for (int k = 0; k < 3; k++) push(10'd11, 32'hC0DE0001, 1'b0, 16'hFFFF);
    req_valid = 2'b01;
    @(negedge wr_clk); #1;
    @(negedge wr_clk); #1;
    @(negedge wr_clk); #1;
    req_valid = 2'b00;
    drain(10);
    @(negedge wr_clk); #1;
    check("count_saturated", 64'(wr_count), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
